// File: rtl/led_mode_scheduler_pkg.sv
// Shared constants for the LED mode scheduler: LED bank width, display
// mode encoding and the helper that walks the button-driven mode cycle.
package led_pkg;

    localparam int LED_W = 10;

    localparam logic [1:0] MODE_ALU   = 2'd0;
    localparam logic [1:0] MODE_MAGIC = 2'd1;
    localparam logic [1:0] MODE_OFF   = 2'd2;
    localparam logic [1:0] MODE_ERR   = 2'd3;

    localparam logic [LED_W-1:0] LEDS_ALL_ON  = '1;
    localparam logic [LED_W-1:0] LEDS_ALL_OFF = '0;

    // The button walks ALU -> MAGIC -> OFF -> ALU; ERR is never reached by a press.
    function automatic logic [1:0] nextDisplayMode(input logic [1:0] cur);
        logic [1:0] nxt;
        case (cur)
            MODE_ALU:   nxt = MODE_MAGIC;
            MODE_MAGIC: nxt = MODE_OFF;
            default:    nxt = MODE_ALU;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/led_mode_scheduler_if.sv
// Bundle of the datapath-facing signals of the LED scheduler: the ALU result
// and its qualifier, the magic pattern, the error pulse, and the scheduler's
// tick strobe, LED drive and current mode.
interface led_mode_scheduler_if;
    import led_pkg::*;

    logic [LED_W-1:0] alu_result;
    logic             alu_valid;
    logic [LED_W-1:0] magic_leds;
    logic             err_req;
    logic             tick;
    logic [LED_W-1:0] leds;
    logic [1:0]       mode;

    // Surrounding datapath / board side.
    modport master (
        output alu_result, alu_valid, magic_leds, err_req,
        input  tick, leds, mode
    );

    // The scheduler itself.
    modport slave (
        input  alu_result, alu_valid, magic_leds, err_req,
        output tick, leds, mode
    );

endinterface

// File: rtl/led_mode_scheduler_button_debounce.sv
// Mode button conditioner: 2-flop synchronizer, stable-level counter, and a
// one-cycle press pulse on each accepted 0->1 change of the debounced level.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synchronized input disagrees with the
    // accepted level; any agreeing cycle clears the count.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer and debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/led_mode_scheduler.sv
// Owns the LED bank: picks ALU latch, magic pattern, all-off or error flash
// each cycle, and generates the display tick that paces the pattern block.
module led_mode_scheduler
    import led_pkg::*;
#(
    parameter int TICK_DIV        = 1048576,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int FLASH_TICKS     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_mode,
    led_mode_scheduler_if.slave  bus
);

    localparam int               TICK_W     = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam int               FLASH_W    = $clog2(FLASH_TICKS + 1);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_TICKS - 1);

    logic [TICK_W-1:0]  tickCnt_q, tickCnt_d;
    logic               tickNow;
    logic [LED_W-1:0]   aluLatch_q, aluLatch_d;
    logic [1:0]         mode_q, mode_d;
    logic [1:0]         savedMode_q, savedMode_d;
    logic [FLASH_W-1:0] flashCnt_q, flashCnt_d;
    logic               flashOn_q, flashOn_d;
    logic [LED_W-1:0]   leds_q, leds_d;
    logic               press;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_mode),
        .press_o (press)
    );

    // Free-running display tick: strobe on the last count, then wrap.
    always_comb begin
        tickNow   = (tickCnt_q == TICK_LAST);
        tickCnt_d = tickNow ? '0 : tickCnt_q + 1'b1;
    end

    // The ALU latch follows alu_valid in every mode so ALU view is fresh on return.
    always_comb begin
        aluLatch_d = bus.alu_valid ? bus.alu_result : aluLatch_q;
    end

    // Mode FSM: error entry/restart beats button presses; presses in ERR are dropped.
    always_comb begin
        mode_d      = mode_q;
        savedMode_d = savedMode_q;
        flashCnt_d  = flashCnt_q;
        flashOn_d   = flashOn_q;
        if (mode_q != MODE_ERR) begin
            if (bus.err_req) begin
                savedMode_d = mode_q;
                mode_d      = MODE_ERR;
                flashCnt_d  = '0;
                flashOn_d   = 1'b1;
            end else if (press) begin
                mode_d = nextDisplayMode(mode_q);
            end
        end else if (bus.err_req) begin
            flashCnt_d = '0;
            flashOn_d  = 1'b1;
        end else if (tickNow) begin
            if (flashCnt_q == FLASH_LAST) begin
                mode_d = savedMode_q;
            end else begin
                flashCnt_d = flashCnt_q + 1'b1;
                flashOn_d  = ~flashOn_q;
            end
        end
    end

    // LED source is chosen from the next state so leds and mode change together.
    always_comb begin
        case (mode_d)
            MODE_ALU:   leds_d = aluLatch_q;
            MODE_MAGIC: leds_d = bus.magic_leds;
            MODE_OFF:   leds_d = LEDS_ALL_OFF;
            default:    leds_d = flashOn_d ? LEDS_ALL_ON : LEDS_ALL_OFF;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tickCnt_q   <= '0;
            aluLatch_q  <= '0;
            mode_q      <= MODE_ALU;
            savedMode_q <= MODE_ALU;
            flashCnt_q  <= '0;
            flashOn_q   <= 1'b0;
            leds_q      <= '0;
        end else begin
            tickCnt_q   <= tickCnt_d;
            aluLatch_q  <= aluLatch_d;
            mode_q      <= mode_d;
            savedMode_q <= savedMode_d;
            flashCnt_q  <= flashCnt_d;
            flashOn_q   <= flashOn_d;
            leds_q      <= leds_d;
        end
    end

    assign bus.tick = tickNow & ~rst;
    assign bus.leds = leds_q;
    assign bus.mode = mode_q;

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Testbench for led_mode_scheduler: directed table and sequences plus random
// traffic, all compared against a behavioural model of the display rules.
module tb_led_mode_scheduler;
    import led_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int DEB      = 3;
    localparam int FLASH    = 4;

    logic clk = 1'b0;
    logic rst;
    logic btn_mode;

    led_mode_scheduler_if bus();

    led_mode_scheduler #(
        .TICK_DIV        (TICK_DIV),
        .DEBOUNCE_CYCLES (DEB),
        .FLASH_TICKS     (FLASH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int failCount  = 0;
    int cycleNum   = 0;

    // Behavioural model state: cycles since reset, display mode, ticks seen in ERR.
    int         mCyc;
    int         mMode;
    int         mSaved;
    int         mFlashed;
    logic [9:0] mLatch;
    logic [9:0] mLeds;
    bit         mLevel;
    bit         mPress;
    bit         btnHist[$];

    typedef struct {
        logic       valid;
        logic [9:0] result;
        logic       expTick;
        logic [1:0] expMode;
        logic [9:0] expLeds;
    } vec_t;

    vec_t vecs[11];

    task automatic checkValue(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycleNum, actual, expected);
        end
    endtask

    task automatic modelReset();
        mCyc     = 0;
        mMode    = 0;
        mSaved   = 0;
        mFlashed = 0;
        mLatch   = '0;
        mLeds    = '0;
        mLevel   = 1'b0;
        mPress   = 1'b0;
        btnHist  = {};
        repeat (5) btnHist.push_back(1'b0);
    endtask

    // One clock edge of the display rules, using the inputs held across the edge.
    task automatic modelEdge();
        bit tickNow;
        bit flip;
        int n;
        if (rst) begin
            modelReset();
            return;
        end
        tickNow = (mCyc % TICK_DIV) == (TICK_DIV - 1);
        mCyc++;
        if (mMode != 3) begin
            if (bus.err_req) begin
                mSaved   = mMode;
                mMode    = 3;
                mFlashed = 0;
            end else if (mPress) begin
                mMode = (mMode + 1) % 3;
            end
        end else begin
            if (bus.err_req) begin
                mFlashed = 0;
            end else if (tickNow) begin
                mFlashed++;
                if (mFlashed == FLASH) mMode = mSaved;
            end
        end
        case (mMode)
            0:       mLeds = mLatch;
            1:       mLeds = bus.magic_leds;
            2:       mLeds = 10'h000;
            default: mLeds = (mFlashed % 2 == 0) ? 10'h3FF : 10'h000;
        endcase
        if (bus.alu_valid) mLatch = bus.alu_result;
        // Level is accepted once DEB consecutive synchronized samples disagree with it.
        btnHist.push_back(btn_mode);
        n    = btnHist.size();
        flip = 1'b1;
        for (int i = 0; i < DEB; i++) begin
            if (btnHist[n - 3 - i] == mLevel) flip = 1'b0;
        end
        mPress = 1'b0;
        if (flip) begin
            mLevel = ~mLevel;
            mPress = mLevel;
        end
        if (btnHist.size() > 16) void'(btnHist.pop_front());
    endtask

    task automatic checkOutput();
        checkValue("tick", int'(bus.tick), ((mCyc % TICK_DIV) == (TICK_DIV - 1)) ? 1 : 0);
        checkValue("mode", int'(bus.mode), mMode);
        checkValue("leds", int'(bus.leds), int'(mLeds));
    endtask

    // Clock one cycle with the currently driven inputs and compare with the model.
    task automatic applyStimulus();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        cycleNum++;
        checkOutput();
    endtask

    task automatic waitErrExit(input string name, output int ticks);
        int guard;
        ticks = 0;
        guard = 0;
        while (bus.mode == MODE_ERR && guard < 60) begin
            if (bus.tick) ticks++;
            applyStimulus();
            guard++;
        end
        checkValue({name, " timeout"}, (guard < 60) ? 0 : 1, 0);
    endtask

    initial begin
        int ticks;
        int t2;
        int holdLeft;

        rst            = 1'b1;
        btn_mode       = 1'b0;
        bus.alu_valid  = 1'b0;
        bus.alu_result = '0;
        bus.magic_leds = '0;
        bus.err_req    = 1'b0;
        modelReset();

        // Reset held for three cycles.
        repeat (3) begin
            applyStimulus();
            checkValue("reset leds", int'(bus.leds), 0);
            checkValue("reset mode", int'(bus.mode), 0);
            checkValue("reset tick", int'(bus.tick), 0);
        end
        rst = 1'b0;

        // Tick phase after release and ALU latch-to-display latency.
        vecs[0]  = '{1'b0, 10'h000, 1'b0, 2'd0, 10'h000};
        vecs[1]  = '{1'b1, 10'h2A5, 1'b0, 2'd0, 10'h000};
        vecs[2]  = '{1'b0, 10'h000, 1'b1, 2'd0, 10'h2A5};
        vecs[3]  = '{1'b0, 10'h155, 1'b0, 2'd0, 10'h2A5};
        vecs[4]  = '{1'b0, 10'h155, 1'b0, 2'd0, 10'h2A5};
        vecs[5]  = '{1'b0, 10'h0AA, 1'b0, 2'd0, 10'h2A5};
        vecs[6]  = '{1'b0, 10'h3FF, 1'b1, 2'd0, 10'h2A5};
        vecs[7]  = '{1'b0, 10'h000, 1'b0, 2'd0, 10'h2A5};
        vecs[8]  = '{1'b0, 10'h001, 1'b0, 2'd0, 10'h2A5};
        vecs[9]  = '{1'b0, 10'h002, 1'b0, 2'd0, 10'h2A5};
        vecs[10] = '{1'b0, 10'h003, 1'b1, 2'd0, 10'h2A5};
        for (int i = 0; i < 11; i++) begin
            bus.alu_valid  = vecs[i].valid;
            bus.alu_result = vecs[i].result;
            applyStimulus();
            checkValue($sformatf("vec%0d tick", i), int'(bus.tick), int'(vecs[i].expTick));
            checkValue($sformatf("vec%0d mode", i), int'(bus.mode), int'(vecs[i].expMode));
            checkValue($sformatf("vec%0d leds", i), int'(bus.leds), int'(vecs[i].expLeds));
        end
        bus.alu_valid = 1'b0;

        // Two-cycle glitch must not step the mode.
        bus.magic_leds = 10'h001;
        btn_mode = 1'b1;
        repeat (2) applyStimulus();
        btn_mode = 1'b0;
        repeat (8) applyStimulus();
        checkValue("glitch mode", int'(bus.mode), 0);

        // Full hold: ALU -> MAGIC, then LEDs follow the pattern with one cycle lag.
        btn_mode = 1'b1;
        repeat (10) applyStimulus();
        btn_mode = 1'b0;
        repeat (8) applyStimulus();
        checkValue("hold1 mode", int'(bus.mode), 1);
        checkValue("magic 001", int'(bus.leds), 10'h001);
        bus.magic_leds = 10'h002;
        applyStimulus();
        checkValue("magic 002", int'(bus.leds), 10'h002);

        // Error flash from MAGIC: immediate all-on, four ticks, back to MAGIC.
        bus.err_req = 1'b1;
        applyStimulus();
        bus.err_req = 1'b0;
        checkValue("err entry mode", int'(bus.mode), 3);
        checkValue("err entry leds", int'(bus.leds), 10'h3FF);
        waitErrExit("flash1", ticks);
        checkValue("flash1 ticks", ticks, FLASH);
        checkValue("flash1 return mode", int'(bus.mode), 1);
        checkValue("flash1 return leds", int'(bus.leds), 10'h002);

        // Restart after two ticks, with a discarded press during the flash.
        bus.err_req = 1'b1;
        applyStimulus();
        bus.err_req = 1'b0;
        ticks = 0;
        t2    = 0;
        while (ticks < 2 && t2 < 40) begin
            if (bus.tick) ticks++;
            if (ticks < 2) applyStimulus();
            t2++;
        end
        checkValue("restart reach", (ticks == 2) ? 1 : 0, 1);
        bus.err_req = 1'b1;
        btn_mode    = 1'b1;
        applyStimulus();
        bus.err_req = 1'b0;
        ticks = 0;
        repeat (9) begin
            if (bus.tick) ticks++;
            applyStimulus();
        end
        btn_mode = 1'b0;
        checkValue("restart still err", int'(bus.mode), 3);
        waitErrExit("restart", t2);
        checkValue("restart ticks", ticks + t2, FLASH);
        checkValue("restart return mode", int'(bus.mode), 1);
        repeat (10) applyStimulus();
        checkValue("press dropped", int'(bus.mode), 1);

        // Step to OFF, then collide err_req with the next press.
        btn_mode = 1'b1;
        repeat (10) applyStimulus();
        btn_mode = 1'b0;
        repeat (8) applyStimulus();
        checkValue("hold2 mode", int'(bus.mode), 2);
        btn_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.err_req = (i == 5);
            applyStimulus();
        end
        bus.err_req = 1'b0;
        btn_mode    = 1'b0;
        checkValue("collision err", int'(bus.mode), 3);
        waitErrExit("collision", ticks);
        checkValue("collision return", int'(bus.mode), 2);

        // Reset in the middle of a flash.
        bus.err_req = 1'b1;
        applyStimulus();
        bus.err_req = 1'b0;
        repeat (3) applyStimulus();
        rst = 1'b1;
        applyStimulus();
        checkValue("rst err leds", int'(bus.leds), 0);
        checkValue("rst err mode", int'(bus.mode), 0);
        rst = 1'b0;
        repeat (20) applyStimulus();
        checkValue("post rst leds", int'(bus.leds), 0);
        checkValue("post rst mode", int'(bus.mode), 0);

        // Random traffic against the model.
        holdLeft = 1;
        for (int i = 0; i < 1500; i++) begin
            holdLeft--;
            if (holdLeft <= 0) begin
                btn_mode = ~btn_mode;
                holdLeft = int'($urandom_range(1, 12));
            end
            bus.err_req    = ($urandom_range(0, 29) == 0);
            bus.alu_valid  = ($urandom_range(0, 3) == 0);
            bus.alu_result = 10'($urandom);
            if ($urandom_range(0, 2) == 0) bus.magic_leds = 10'($urandom);
            rst = ($urandom_range(0, 399) == 0);
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
